// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
// instr_loader_pkg : shared FSM encoding and sizing defaults for instr_loader
// Revision 1.0
// ============================================================================
package instr_loader_pkg;

   localparam int MEM_BYTES_DEF = 256;
   localparam int MAX_WORDS_DEF = MEM_BYTES_DEF / 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_WRITE  = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_e;

   function automatic logic state_is_busy(input state_e s);
      return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_WRITE);
   endfunction

endpackage : instr_loader_pkg
`default_nettype wire

// File: rtl/instr_loader_if.sv
`default_nettype none
// ============================================================================
// instr_loader_if : byte stream in, instruction-memory write port out
// Revision 1.0
// ============================================================================
interface instr_loader_if;

   logic        load_req;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [31:0] ext_instr;
   logic [31:0] ext_instr_addr;
   logic        ext_instr_en;
   logic        start;
   logic        busy;
   logic        err;

   modport master (
      output load_req, byte_in, byte_valid,
      input  byte_ready, ext_instr, ext_instr_addr, ext_instr_en, start, busy, err
   );

   modport slave (
      input  load_req, byte_in, byte_valid,
      output byte_ready, ext_instr, ext_instr_addr, ext_instr_en, start, busy, err
   );

endinterface : instr_loader_if
`default_nettype wire

// File: rtl/instr_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// byte_assembler : MSB-first 4-byte shift register with 2-bit byte index
// Revision 1.0
// ============================================================================
module byte_assembler (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        clr_i,
   input  wire logic        shift_i,
   input  wire logic [7:0]  byte_i,
   output logic [31:0]      word_o,
   output logic             last_o
);

   logic [31:0] word_q;
   logic [1:0]  idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= 32'd0;
         idx_q  <= 2'd0;
      end else if (clr_i) begin
         idx_q  <= 2'd0;
      end else if (shift_i) begin
         word_q <= {word_q[23:0], byte_i};
         idx_q  <= idx_q + 2'd1;
      end
   end

   assign word_o = word_q;
   assign last_o = shift_i && (idx_q == 2'd3);

endmodule : byte_assembler
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// instr_loader : loads a length-prefixed byte stream into instruction memory
// Revision 1.0
// ============================================================================
module instr_loader
   import instr_loader_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int MAX_WORDS = MEM_BYTES / 4
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   instr_loader_if.slave  ldr_if
);

   localparam int          AW          = $clog2(MEM_BYTES);
   localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

   state_e         state_q, state_d;
   logic [7:0]     len_hi_q;
   logic [15:0]    remaining_q;
   logic [AW-1:0]  addr_q;

   logic           w_byte_ready;
   logic           w_busy;
   logic           w_start;
   logic           w_err;
   logic           w_wr_en;
   logic           w_xfer;
   logic [15:0]    w_len;
   logic           w_len_zero;
   logic           w_len_over;
   logic           w_asm_clr;
   logic           w_asm_shift;
   logic           w_asm_last;
   logic [31:0]    w_asm_word;

   assign w_xfer     = ldr_if.byte_valid && w_byte_ready;
   assign w_len      = {len_hi_q, ldr_if.byte_in};
   assign w_len_zero = (w_len == 16'd0);
   assign w_len_over = ({1'b0, w_len} > MAX_WORDS_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (ldr_if.load_req) state_d = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (w_xfer) state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (w_xfer) begin
               if (w_len_zero)      state_d = ST_DONE;
               else if (w_len_over) state_d = ST_ERR;
               else                 state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_asm_last) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            state_d = (remaining_q == 16'd1) ? ST_DONE : ST_DATA;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      w_byte_ready = 1'b0;
      w_wr_en      = 1'b0;
      w_start      = 1'b0;
      w_err        = 1'b0;
      w_busy       = state_is_busy(state_q);
      unique case (state_q)
         ST_LEN_HI, ST_LEN_LO, ST_DATA: w_byte_ready = 1'b1;
         ST_WRITE:                      w_wr_en      = 1'b1;
         ST_DONE:                       w_start      = 1'b1;
         ST_ERR:                        w_err        = 1'b1;
         default:                       ;
      endcase
   end

   // Address and remaining count are only touched once per word, in WRITE,
   // so ext_instr_addr stays stable throughout the strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_hi_q    <= 8'd0;
         remaining_q <= 16'd0;
         addr_q      <= '0;
      end else begin
         unique case (state_q)
            ST_LEN_HI: begin
               if (w_xfer) len_hi_q <= ldr_if.byte_in;
            end
            ST_LEN_LO: begin
               if (w_xfer) begin
                  remaining_q <= w_len;
                  addr_q      <= '0;
               end
            end
            ST_WRITE: begin
               addr_q      <= addr_q + AW'(4);
               remaining_q <= remaining_q - 16'd1;
            end
            default: ;
         endcase
      end
   end

   assign w_asm_clr   = (state_q == ST_LEN_LO) && w_xfer;
   assign w_asm_shift = (state_q == ST_DATA) && w_xfer;

   byte_assembler u_byte_assembler (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (w_asm_clr),
      .shift_i (w_asm_shift),
      .byte_i  (ldr_if.byte_in),
      .word_o  (w_asm_word),
      .last_o  (w_asm_last)
   );

   assign ldr_if.byte_ready     = w_byte_ready;
   assign ldr_if.busy           = w_busy;
   assign ldr_if.start          = w_start;
   assign ldr_if.err            = w_err;
   assign ldr_if.ext_instr_en   = w_wr_en;
   assign ldr_if.ext_instr      = w_asm_word;
   assign ldr_if.ext_instr_addr = 32'(addr_q);

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
// tb_instr_loader : randomized loads checked against a queue-based write model
// Revision 1.0
// ============================================================================
module tb_instr_loader;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_loader_if bus ();

   instr_loader #(.MEM_BYTES(256), .MAX_WORDS(64)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ldr_if (bus)
   );

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] addr;
   } wr_t;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cycle = 0;
   int         last_strobe = -100;
   wr_t        exp_q[$];
   wr_t        log_q[$];
   logic [7:0] prog [0:255];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Every strobe must match the next expected (word, address) pair.
   always @(negedge clk) begin
      wr_t e;
      cycle++;
      if (rst_n) begin
         check("start_busy_exclusive", 32'(bus.start & bus.busy), 32'd0);
         if (bus.ext_instr_en) begin
            check("ready_low_in_write", 32'(bus.byte_ready), 32'd0);
            check("write_spacing_ge5", 32'(cycle - last_strobe >= 5), 32'd1);
            last_strobe = cycle;
            log_q.push_back({bus.ext_instr, bus.ext_instr_addr});
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("ext_instr", bus.ext_instr, e.word);
               check("ext_instr_addr", bus.ext_instr_addr, e.addr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_load();
      bus.load_req = 1'b1;
      tick();
      bus.load_req = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit lr);
      bit acc = 1'b0;
      repeat (gap) begin
         bus.byte_valid = 1'b0;
         bus.byte_in    = 8'($urandom);
         tick();
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = b;
      bus.load_req   = lr;
      for (int i = 0; i < 64 && !acc; i++) begin
         @(negedge clk);
         acc = bus.byte_ready;
         tick();
         bus.load_req = 1'b0;
      end
      bus.byte_valid = 1'b0;
      bus.byte_in    = 8'($urandom);
      check("byte_accepted", 32'(acc), 32'd1);
   endtask

   task automatic run_load(input int n, input int max_gap, input bit rand_prog, input int lr_at);
      logic [15:0] nn = 16'(n);
      if (n >= 1 && n <= 64) begin
         for (int k = 0; k < n; k++) begin
            if (rand_prog) begin
               for (int j = 0; j < 4; j++) prog[4*k+j] = 8'($urandom);
            end
            exp_q.push_back({prog[4*k], prog[4*k+1], prog[4*k+2], prog[4*k+3], 32'(4*k)});
         end
      end
      pulse_load();
      @(negedge clk);
      check("busy_after_load_req", 32'(bus.busy), 32'd1);
      check("err_cleared_by_load", 32'(bus.err), 32'd0);
      check("start_cleared_by_load", 32'(bus.start), 32'd0);
      tick();
      send_byte(nn[15:8], $urandom_range(0, max_gap), 1'b0);
      send_byte(nn[7:0],  $urandom_range(0, max_gap), 1'b0);
      if (n == 0) begin
         @(negedge clk);
         check("n0_start", 32'(bus.start), 32'd1);
         check("n0_busy", 32'(bus.busy), 32'd0);
      end else if (n > 64) begin
         @(negedge clk);
         check("ovf_err", 32'(bus.err), 32'd1);
         check("ovf_start", 32'(bus.start), 32'd0);
         check("ovf_busy", 32'(bus.busy), 32'd0);
         repeat (3) @(negedge clk);
         check("ovf_err_held", 32'(bus.err), 32'd1);
      end else begin
         for (int i = 0; i < 4*n; i++)
            send_byte(prog[i], $urandom_range(0, max_gap), (i == lr_at));
         @(negedge clk);
         @(negedge clk);
         check("done_start", 32'(bus.start), 32'd1);
         check("done_busy", 32'(bus.busy), 32'd0);
         check("done_ready", 32'(bus.byte_ready), 32'd0);
         check("all_writes_seen", 32'(exp_q.size()), 32'd0);
      end
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.load_req   = 1'b0;
      bus.byte_in    = 8'd0;
      bus.byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ext_instr", bus.ext_instr, 32'd0);
      check("rst_addr", bus.ext_instr_addr, 32'd0);
      check("rst_en", 32'(bus.ext_instr_en), 32'd0);
      check("rst_start", 32'(bus.start), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_ready", 32'(bus.byte_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      tick();

      // Two-word reference program
      prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h04;
      prog[4] = 8'h20; prog[5] = 8'h42; prog[6] = 8'h00; prog[7] = 8'h07;
      log_q.delete();
      run_load(2, 0, 1'b0, -1);
      check("ref_count", 32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         check("ref_w0", log_q[0].word, 32'h8C010004);
         check("ref_a0", log_q[0].addr, 32'h0);
         check("ref_w1", log_q[1].word, 32'h20420007);
         check("ref_a1", log_q[1].addr, 32'h4);
      end

      run_load(0, 1, 1'b1, -1);
      run_load(65, 1, 1'b1, -1);

      log_q.delete();
      run_load(64, 3, 1'b1, -1);
      check("full_count", 32'(log_q.size()), 32'd64);
      if (log_q.size() == 64) check("full_last_addr", log_q[63].addr, 32'hFC);

      run_load(5, 2, 1'b1, 6);

      // Reset in the middle of the data phase
      pulse_load();
      tick();
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h04, 0, 1'b0);
      send_byte(8'hA5, 1, 1'b0);
      send_byte(8'h5A, 0, 1'b0);
      check("pre_rst_low_half", {16'd0, bus.ext_instr[15:0]}, 32'h0000A55A);
      check("pre_rst_busy", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_ext_instr", bus.ext_instr, 32'd0);
      check("midrst_addr", bus.ext_instr_addr, 32'd0);
      check("midrst_busy", 32'(bus.busy), 32'd0);
      check("midrst_ready", 32'(bus.byte_ready), 32'd0);
      check("midrst_en", 32'(bus.ext_instr_en), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         bus.byte_valid = 1'b1;
         bus.byte_in    = 8'($urandom);
         tick();
      end
      bus.byte_valid = 1'b0;
      check("post_rst_idle", 32'(bus.busy), 32'd0);
      log_q.delete();
      run_load(1, 1, 1'b1, -1);
      check("reload_addr0", 32'(log_q.size() == 1 && log_q[0].addr == 32'd0), 32'd1);

      for (int t = 0; t < 14; t++) begin
         int r = $urandom_range(0, 9);
         int n;
         if (r == 0)      n = 0;
         else if (r == 1) n = $urandom_range(65, 65535);
         else             n = $urandom_range(1, 8);
         run_load(n, 3, 1'b1, (r == 2) ? 3 : -1);
      end

      repeat (4) tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_instr_loader
`default_nettype wire
